// File: rtl/alu_issue.sv
// Execute-stage issue wrapper: decodes ALUOp/funct into ALUCtl, two-stage pipeline around the alu.
// Latency 2 cycles from input handshake to out_valid; full throughput; in_ready combinational from out_ready.
// Backpressure: buffers two operations while out_ready is low. ALU_ISSUE_ERR_EN enables illegal-op flagging.

// Combinational 32-bit ALU selected by the 4-bit ALUCtl code.
// Latency 0 (purely combinational).
// No backpressure; the result follows the inputs.
module alu (
    input  logic [3:0]  i_ctl,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_zero
);
    always_comb begin
        o_result = 32'd0;
        case (i_ctl)
            4'b0010: o_result = i_a + i_b;
            4'b0110: o_result = i_a - i_b;
            4'b0000: o_result = i_a & i_b;
            4'b0001: o_result = i_a | i_b;
            4'b0111: o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
            default: o_result = 32'd0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);
endmodule

// Issue wrapper: decode stage D, ALU between D and R, result register R.
// Latency: handshake in cycle N -> out_valid in cycle N+2.
// Backpressure: both stages hold under !out_ready; in_ready falls once both are full.
module alu_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic             in_opb5,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      op_count
);
    logic [3:0]       w_ctl;
    logic             w_ill;
    logic             w_r_adv;
    logic             w_d_adv;
    logic             w_in_hs;
    logic             w_out_hs;
    logic [31:0]      w_alu_result;
    logic             w_alu_zero;

    logic             r_d_valid;
    logic [3:0]       r_d_ctl;
    logic [31:0]      r_d_a;
    logic [31:0]      r_d_b;
    logic [TAG_W-1:0] r_d_tag;
    logic             r_d_ill;

    logic             r_o_valid;
    logic [31:0]      r_o_result;
    logic             r_o_zero;
    logic             r_o_err;
    logic [TAG_W-1:0] r_o_tag;
    logic [15:0]      r_op_count;

    // Without error detection, illegal encodings keep the add default and are not flagged.
    always_comb begin
        w_ctl = 4'b0010;
        w_ill = 1'b0;
        case (in_aluop)
            2'b00: w_ctl = 4'b0010;
            2'b01: w_ctl = 4'b0110;
            2'b10: begin
                case (in_funct3)
                    3'b000:  w_ctl = (in_funct7b5 && in_opb5) ? 4'b0110 : 4'b0010;
                    3'b111:  w_ctl = 4'b0000;
                    3'b110:  w_ctl = 4'b0001;
                    3'b010:  w_ctl = 4'b0111;
                    default: begin
`ifdef ALU_ISSUE_ERR_EN
                        w_ctl = 4'b1111;
                        w_ill = 1'b1;
`endif
                    end
                endcase
            end
            default: begin
`ifdef ALU_ISSUE_ERR_EN
                w_ctl = 4'b1111;
                w_ill = 1'b1;
`endif
            end
        endcase
    end

    assign w_r_adv  = !r_o_valid || out_ready;
    assign w_d_adv  = r_d_valid && w_r_adv;
    assign in_ready = !r_d_valid || w_r_adv;
    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = r_o_valid && out_ready;

    alu u_alu (
        .i_ctl    (r_d_ctl),
        .i_a      (r_d_a),
        .i_b      (r_d_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_valid <= 1'b0;
            r_d_ctl   <= 4'd0;
            r_d_a     <= 32'd0;
            r_d_b     <= 32'd0;
            r_d_tag   <= '0;
            r_d_ill   <= 1'b0;
        end else begin
            if (in_ready) begin
                r_d_valid <= in_valid;
            end
            if (w_in_hs) begin
                r_d_ctl <= w_ctl;
                r_d_a   <= in_a;
                r_d_b   <= in_b;
                r_d_tag <= in_tag;
                r_d_ill <= w_ill;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_valid  <= 1'b0;
            r_o_result <= 32'd0;
            r_o_zero   <= 1'b0;
            r_o_err    <= 1'b0;
            r_o_tag    <= '0;
            r_op_count <= 16'd0;
        end else begin
            if (w_r_adv) begin
                r_o_valid <= w_d_adv;
            end
            if (w_d_adv) begin
                r_o_result <= w_alu_result;
                r_o_zero   <= w_alu_zero;
                r_o_err    <= r_d_ill;
                r_o_tag    <= r_d_tag;
            end
            if (w_out_hs) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign out_valid  = r_o_valid;
    assign out_result = r_o_result;
    assign out_zero   = r_o_zero;
    assign out_err    = r_o_err;
    assign out_tag    = r_o_tag;
    assign op_count   = r_op_count;
endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue wrapper around the team's 32-bit combinational `alu`. It accepts decoded instruction fields and operands over a valid/ready handshake and translates `ALUOp`/funct bits into the 4-bit `ALUCtl` encoding. It registers the operation and then captures the ALU result and zero flag into an output register. It sits between the decode stage and writeback and provides two-stage pipelining with full-throughput backpressure.

## Interface
- `TAG_W`, 5: width of the pass-through tag (destination register index).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_aluop` in 2: 00 = add (load/store address), 01 = sub (branch compare), 10 = funct-decoded, 11 = illegal.
- `in_funct3` in 3: instruction funct3.
- `in_funct7b5` in 1: instruction bit 30.
- `in_opb5` in 1: opcode bit 5 (1 = R-type, 0 = I-type).
- `in_a`, `in_b` in 32: operands.
- `in_tag` in `TAG_W`: carried unchanged to the output.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `out_result` out 32: ALU result.
- `out_zero` out 1: result == 0.
- `out_err` out 1: illegal operation (see Configuration).
- `out_tag` out `TAG_W`: tag of the result.
- `op_count` out 16: count of results consumed; wraps 0xFFFF→0x0000.

## Operation
- Decode (combinational, at input):
  - `aluop` 00 → 0010 (add); 01 → 0110 (sub).
  - `aluop` 10, by `funct3`:
    - 000: 0110 if `funct7b5 && opb5`, else 0010.
    - 111 → 0000 (and); 110 → 0001 (or); 010 → 0111 (slt, signed compare).
    - Any other `funct3` is illegal.
  - `aluop` 11 is illegal.
- Illegal decode produces `ALUCtl` = 1111. The ALU default then yields result 0 and zero = 1.
- Stage D register holds `d_valid`, `ALUCtl`, `a`, `b`, `tag`, `illegal`. It loads on input handshake.
- The ALU is driven combinationally from stage D.
- Stage R register holds `r_valid`, `result`, `zero`, `err`, `tag`. It loads from the ALU output when stage D advances.
- Advance rules:
  - `r_adv = !r_valid || out_ready`.
  - `d_adv = d_valid && r_adv`.
  - `in_ready = !d_valid || r_adv`.
  - `in_ready` is combinational from `out_ready`.
- Valid update rules:
  - `d_valid` next = `in_valid && in_ready`, or holds when stage D is stalled.
  - `r_valid` next = `d_adv`, or holds when `!out_ready`.
- `op_count` increments on each output handshake.
- Reset, asynchronous and possible mid-operation:
  - `d_valid`, `r_valid` = 0; all data registers = 0; `op_count` = 0.
  - Outputs after reset: `out_valid` 0, `out_result` 0, `out_zero` 0, `out_err` 0, `out_tag` 0, `in_ready` 1.
  - In-flight operations are discarded; nothing is replayed.
- Data on `out_*` is stable while `out_valid && !out_ready`.
- Simultaneous input handshake and output handshake with both stages full: both stages shift in the same cycle with no bubble.

## Timing
- Latency: input handshake in cycle N → `out_valid` in cycle N+2 when unstalled.
- Throughput: one operation per cycle with `out_ready` held at 1.
- Backpressure: with `out_ready` = 0, two operations are buffered and then `in_ready` falls.
  - `in_ready` rises in the same cycle `out_ready` returns to 1.
- The asynchronous reset assertion clears state immediately. Deassertion must be synchronised externally to `clk`.

## Configuration
- `ALU_ISSUE_ERR_EN` defined:
  - Illegal decode drives `ALUCtl` 1111.
  - The result is marked with `out_err` = 1, `out_result` = 0, `out_zero` = 1.
  - It still counts in `op_count`.
- Undefined:
  - No illegal detection; `out_err` is tied 0.
  - Illegal combinations decode to 0010 (add).

## Test plan
- Reset then single op: `aluop` 10, `funct3` 000, `funct7b5` 1, `opb5` 1, a=10, b=10 → two cycles later `out_result` 0, `out_zero` 1, tag preserved, `op_count` 1.
- Back-to-back stream of 4 ops (add 3+4, and 0xF0&0x3C, or 0xF0|0x0F, slt 5<7), `out_ready` = 1 → results 7, 0x30, 0xFF, 1 on consecutive cycles, no bubbles.
- Backpressure: `out_ready` = 0 while issuing 3 ops → `in_ready` low after 2 accepted. Hold 5 cycles with outputs stable, release → all 3 emerge in order with no loss or duplication.
- I-type `funct3` 000 with `funct7b5` = 1, `opb5` = 0, a=1, b=2 → add, result 3 (not sub).
- Illegal `aluop` 11 with a=5, b=5:
  - With `ALU_ISSUE_ERR_EN` → `out_err` 1, result 0, zero 1.
  - Without it → result 10, `out_err` 0.
- `rst_n` pulsed low with both stages full → `out_valid` 0 immediately and `op_count` 0. The next op after release completes normally with 2-cycle latency.
